insn_fetch: RTL and testbench

INSN_FETCH -- requirements
Module: insn_fetch

---
 rtl/insn_fetch_pkg.sv | 12 +
 rtl/insn_fetch_if.sv | 24 ++
 rtl/icache_store.sv | 43 ++++
 rtl/insn_fetch.sv | 112 +++++++++++
 tb/tb_insn_fetch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/insn_fetch_pkg.sv
// Shared types for the instruction fetch cache.
// Holds the FSM state encoding (LOOKUP=0, FILL=1) and the word width.
package insn_fetch_pkg;

  localparam int unsigned WordW = 32;

  typedef enum logic [0:0] {
    StLookup = 1'b0,
    StFill   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/insn_fetch_if.sv
// Core-side fetch port and memory-side refill port of the instruction fetch cache.
// The master modport is the cache; the slave modport is the core/memory environment.
interface insn_fetch_if;

  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_valid;
  logic        flush;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_ack;
  logic [31:0] m_data;

  modport master (
    input  i_addr, flush, m_ack, m_data,
    output i_data, i_valid, m_req, m_addr
  );

  modport slave (
    output i_addr, flush, m_ack, m_data,
    input  i_data, i_valid, m_req, m_addr
  );

endinterface

// File: rtl/icache_store.sv
// Direct-mapped line storage: data, tag and valid arrays.
// It has one combinational read port, one write port and a clear-all for the valid bits.
module icache_store #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 28
) (
  input  logic                  clk,
  input  logic                  clear_all,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [31:0]           rd_data,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid
);

  localparam int unsigned Lines = 2 ** INDEX_BITS;

  logic [31:0]         data_q  [Lines];
  logic [TAG_BITS-1:0] tag_q   [Lines];
  logic [Lines-1:0]    valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index] <= wr_data;
      tag_q[wr_index]  <= wr_tag;
    end
  end

  // A write in the same cycle as clear_all always carries wr_valid=0, so ordering is harmless.
  always_ff @(posedge clk) begin
    if (clear_all) valid_q <= '0;
    if (wr_en) valid_q[wr_index] <= wr_valid;
  end

  assign rd_data  = data_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/insn_fetch.sv
// Direct-mapped instruction fetch cache with a LOOKUP/FILL refill FSM.
// Define INSN_FETCH_STATS_EN to add the hit_count/miss_count outputs.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter int unsigned INDEX_BITS        = 4,
  parameter int unsigned RESET_INDEX_CLEAR = 1
) (
  input  logic         clk,
  input  logic         reset,
  insn_fetch_if.master bus
`ifdef INSN_FETCH_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned TagBits = WordW - INDEX_BITS;

  fetch_state_e        state_q, state_d;
  logic [31:0]         m_addr_q, m_addr_d;
  logic                flush_pend_q, flush_pend_d;
  logic [31:0]         rd_data;
  logic [TagBits-1:0]  rd_tag;
  logic                rd_valid;
  logic                hit;
  logic                i_valid;
  logic                wr_en;
  logic                wr_valid;
  logic                clear_all;

  assign hit = (state_q == StLookup) && rd_valid && (rd_tag == bus.i_addr[31:INDEX_BITS]);
  assign clear_all = bus.flush || (reset && (RESET_INDEX_CLEAR != 0));

  icache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TagBits)
  ) u_store (
    .clk       (clk),
    .clear_all (clear_all),
    .rd_index  (bus.i_addr[INDEX_BITS-1:0]),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_index  (m_addr_q[INDEX_BITS-1:0]),
    .wr_tag    (m_addr_q[31:INDEX_BITS]),
    .wr_data   (bus.m_data),
    .wr_valid  (wr_valid)
  );

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    m_addr_q     <= m_addr_d;
    flush_pend_q <= flush_pend_d;
  end

  always_comb begin
    state_d      = state_q;
    m_addr_d     = m_addr_q;
    flush_pend_d = flush_pend_q;
    wr_en        = 1'b0;
    wr_valid     = 1'b0;
    i_valid      = 1'b0;
    if (reset) begin
      state_d      = StLookup;
      m_addr_d     = '0;
      flush_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        StLookup: begin
          i_valid = hit && !bus.flush;
          if (!bus.flush && !hit) begin
            state_d      = StFill;
            m_addr_d     = bus.i_addr;
            flush_pend_d = 1'b0;
          end
        end
        StFill: begin
          // A flush anywhere in the fill means the returning line is stale.
          if (bus.flush) flush_pend_d = 1'b1;
          if (bus.m_ack) begin
            wr_en        = 1'b1;
            wr_valid     = !(bus.flush || flush_pend_q);
            state_d      = StLookup;
            flush_pend_d = 1'b0;
          end
        end
        default: state_d = StLookup;
      endcase
    end
  end

  assign bus.i_valid = i_valid;
  assign bus.i_data  = rd_data;
  assign bus.m_req   = (state_q == StFill) && !reset;
  assign bus.m_addr  = reset ? '0 : m_addr_q;

`ifdef INSN_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (i_valid) hit_count <= hit_count + 32'd1;
      if ((state_q == StLookup) && (state_d == StFill)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_insn_fetch.sv
// Directed self-checking bench for insn_fetch (INDEX_BITS=4, RESET_INDEX_CLEAR=1).
// Counter checks run only when INSN_FETCH_STATS_EN is defined.
module tb_insn_fetch;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  insn_fetch_if bus ();

`ifdef INSN_FETCH_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  insn_fetch #(
    .INDEX_BITS        (4),
    .RESET_INDEX_CLEAR (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef INSN_FETCH_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.flush  = 1'b0;
    bus.m_ack  = 1'b0;
    bus.m_data = '0;
    bus.i_addr = '0;
    tick();
    tick();
    #1;
    check("rst_ivalid", 32'(bus.i_valid), 32'd0);
    check("rst_mreq", 32'(bus.m_req), 32'd0);
    check("rst_maddr", bus.m_addr, 32'd0);

    // Cold miss, ack three cycles after m_req rises
    reset = 1'b0;
    bus.i_addr = 32'h0000_1000;
    #1;
    check("cold_ivalid", 32'(bus.i_valid), 32'd0);
    check("cold_lookup_mreq", 32'(bus.m_req), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("cold_fill_mreq", 32'(bus.m_req), 32'd1);
      check("cold_fill_maddr", bus.m_addr, 32'h0000_1000);
      tick();
    end
    bus.m_ack  = 1'b1;
    bus.m_data = 32'hDEAD_BEEF;
    #1;
    check("cold_ack_ivalid", 32'(bus.i_valid), 32'd0);
    check("cold_ack_mreq", 32'(bus.m_req), 32'd1);
    tick();
    bus.m_ack  = 1'b0;
    bus.m_data = '0;
    #1;
    check("cold_hit_ivalid", 32'(bus.i_valid), 32'd1);
    check("cold_hit_data", bus.i_data, 32'hDEAD_BEEF);
    check("cold_hit_mreq", 32'(bus.m_req), 32'd0);

    // Refetch hit, then conflict on the same index
    tick();
    #1;
    check("refetch_ivalid", 32'(bus.i_valid), 32'd1);
    check("refetch_mreq", 32'(bus.m_req), 32'd0);
    bus.i_addr = 32'h0000_1010;
    #1;
    check("conflict_ivalid", 32'(bus.i_valid), 32'd0);
    tick();
    #1;
    check("conflict_mreq", 32'(bus.m_req), 32'd1);
    check("conflict_maddr", bus.m_addr, 32'h0000_1010);
    bus.m_ack  = 1'b1;
    bus.m_data = 32'h1111_1111;
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("conflict_hit_ivalid", 32'(bus.i_valid), 32'd1);
    check("conflict_hit_data", bus.i_data, 32'h1111_1111);
    bus.i_addr = 32'h0000_1000;
    #1;
    check("evicted_ivalid", 32'(bus.i_valid), 32'd0);
    tick();
    #1;
    check("evicted_mreq", 32'(bus.m_req), 32'd1);
    check("evicted_maddr", bus.m_addr, 32'h0000_1000);
    bus.m_ack  = 1'b1;
    bus.m_data = 32'hDEAD_BEEF;
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("evicted_refill_data", bus.i_data, 32'hDEAD_BEEF);

    // Flush pulse mid-fill, ack later
    bus.i_addr = 32'h0000_2004;
    tick();
    #1;
    check("fflush_mreq0", 32'(bus.m_req), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.i_addr = 32'h0000_9994;
    tick();
    #1;
    check("fflush_mreq1", 32'(bus.m_req), 32'd1);
    check("fflush_maddr_held", bus.m_addr, 32'h0000_2004);
    bus.i_addr = 32'h0000_2004;
    bus.m_ack  = 1'b1;
    bus.m_data = 32'hA5A5_A5A5;
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("fflush_after_ack_mreq", 32'(bus.m_req), 32'd0);
    check("fflush_after_ack_ivalid", 32'(bus.i_valid), 32'd0);
    tick();
    #1;
    check("fflush_refill_mreq", 32'(bus.m_req), 32'd1);
    check("fflush_refill_maddr", bus.m_addr, 32'h0000_2004);
    bus.m_ack = 1'b1;
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("fflush_refill_data", bus.i_data, 32'hA5A5_A5A5);
    check("fflush_refill_ivalid", 32'(bus.i_valid), 32'd1);

    // Flush coincident with m_ack
    bus.i_addr = 32'h0000_3008;
    tick();
    #1;
    check("coflush_mreq", 32'(bus.m_req), 32'd1);
    bus.m_ack  = 1'b1;
    bus.flush  = 1'b1;
    bus.m_data = 32'h1234_5678;
    tick();
    bus.m_ack = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("coflush_ivalid", 32'(bus.i_valid), 32'd0);
    tick();
    #1;
    check("coflush_rereq", 32'(bus.m_req), 32'd1);
    check("coflush_maddr", bus.m_addr, 32'h0000_3008);
    bus.m_ack = 1'b1;
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("coflush_hit_data", bus.i_data, 32'h1234_5678);

    // Reset mid-fill, ack in the following cycle
    bus.i_addr = 32'h0000_400C;
    tick();
    #1;
    check("rfill_mreq", 32'(bus.m_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rfill_rst_mreq", 32'(bus.m_req), 32'd0);
    check("rfill_rst_ivalid", 32'(bus.i_valid), 32'd0);
    check("rfill_rst_maddr", bus.m_addr, 32'd0);
    tick();
    reset      = 1'b0;
    bus.m_ack  = 1'b1;
    bus.m_data = 32'h0BAD_0BAD;
    #1;
    check("rfill_late_ack_mreq", 32'(bus.m_req), 32'd0);
    check("rfill_late_ack_ivalid", 32'(bus.i_valid), 32'd0);
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("rfill_ack_ignored_ivalid", 32'(bus.i_valid), 32'd0);
    check("rfill_rereq", 32'(bus.m_req), 32'd1);
    bus.m_ack  = 1'b1;
    bus.m_data = 32'h400C_400C;
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("rfill_refill_data", bus.i_data, 32'h400C_400C);
    bus.i_addr = 32'h0000_3008;
    #1;
    check("rst_cleared_line", 32'(bus.i_valid), 32'd0);

`ifdef INSN_FETCH_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.i_addr = 32'h0000_5000;
    #1;
    check("stats_rst_hit", hit_count, 32'd0);
    check("stats_rst_miss", miss_count, 32'd0);
    tick();
    bus.m_ack  = 1'b1;
    bus.m_data = 32'h0000_0055;
    tick();
    bus.m_ack = 1'b0;
    #1;
    check("stats_hit_ivalid", 32'(bus.i_valid), 32'd1);
    repeat (5) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("stats_miss_count", miss_count, 32'd1);
    check("stats_hit_count", hit_count, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
